// File: rtl/ternary_neuron_accum.sv
// Ternary neuron back end: accumulates pos-neg popcounts per neuron, applies
// a two-threshold activation. Optional clamp when ACC_SAT_EN is defined.
module ternary_neuron_accum #(
  parameter int CNT_W   = 4,
  parameter int ACC_W   = 8,
  parameter int CHUNK_W = 4,
  parameter int THR_HI  = 2,
  parameter int THR_LO  = -2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CNT_W-1:0]   in_pos,
  input  logic [CNT_W-1:0]   in_neg,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_act,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CHUNK_W:0]   out_chunks,
  output logic               out_sat,
  output logic               out_forced
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } state_e;

`ifdef ACC_SAT_EN
  localparam int DW = ACC_W + 1;
  localparam int SW = ACC_W + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};
`else
  // Wrapping mod 2^ACC_W only needs the low ACC_W bits of the difference
  localparam int DW = ACC_W;
`endif

  localparam logic signed [ACC_W-1:0] THR_HI_C = ACC_W'(THR_HI);
  localparam logic signed [ACC_W-1:0] THR_LO_C = ACC_W'(THR_LO);
  localparam logic [CHUNK_W:0] CNT_LAST =
    (CHUNK_W+1)'((1 << CHUNK_W) - 1);
  localparam logic [CHUNK_W:0] CNT_ONE = (CHUNK_W+1)'(1);

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CHUNK_W:0]        cnt_q, cnt_d;
  logic [1:0]              act_q, act_d;
  logic [ACC_W-1:0]        sum_q, sum_d;
  logic [CHUNK_W:0]        chunks_q, chunks_d;
  logic                    forced_q, forced_d;

  logic signed [DW-1:0]    delta;
  logic signed [ACC_W-1:0] acc_next;
  logic [1:0]              act_next;
  logic                    beat;
  logic                    at_limit;
  logic                    close;
  logic                    hs;

  always_comb begin
    delta = $signed(DW'(in_pos) - DW'(in_neg));
  end

`ifdef ACC_SAT_EN
  logic signed [SW-1:0] sum_w;
  logic                 clamp;
  logic                 sat_q, sat_d;

  always_comb begin
    sum_w    = SW'(acc_q) + SW'(delta);
    clamp    = (sum_w[SW-1:ACC_W-1] != '0) &&
               (sum_w[SW-1:ACC_W-1] != '1);
    acc_next = sum_w[ACC_W-1:0];
    if (clamp) begin
      acc_next = sum_w[SW-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (beat && clamp) begin
      sat_d = 1'b1;
    end
    if (hs) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign out_sat = sat_q;
`else
  always_comb begin
    acc_next = acc_q + delta;
  end

  assign out_sat = 1'b0;
`endif

  always_comb begin
    act_next = 2'b00;
    if (acc_next >= THR_HI_C) begin
      act_next = 2'b01;
    end else if (acc_next <= THR_LO_C) begin
      act_next = 2'b11;
    end
  end

  assign beat     = in_valid && in_ready;
  assign at_limit = (cnt_q == CNT_LAST);
  assign close    = beat && (in_last || at_limit);
  assign hs       = (state_q == RESULT) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          state_d = close ? RESULT : ACCUM;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = (state_q != RESULT);
    out_valid = (state_q == RESULT);
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    sum_d    = sum_q;
    chunks_d = chunks_q;
    forced_d = forced_q;
    if (beat) begin
      acc_d = acc_next;
      cnt_d = cnt_q + CNT_ONE;
    end
    if (close) begin
      sum_d    = acc_next;
      chunks_d = cnt_q + CNT_ONE;
      act_d    = act_next;
      forced_d = at_limit && !in_last;
    end
    if (hs) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      act_q    <= '0;
      sum_q    <= '0;
      chunks_q <= '0;
      forced_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      sum_q    <= sum_d;
      chunks_q <= chunks_d;
      forced_q <= forced_d;
    end
  end

  assign out_act    = act_q;
  assign out_sum    = sum_q;
  assign out_chunks = chunks_q;
  assign out_forced = forced_q;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum with default parameters.
// Expectations for the 16x(15,0) neuron follow ACC_SAT_EN.
module tb_ternary_neuron_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_pos = '0;
  logic [3:0] in_neg = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_act;
  logic [7:0] out_sum;
  logic [4:0] out_chunks;
  logic       out_sat;
  logic       out_forced;

  int errors = 0;
  int checks = 0;

  ternary_neuron_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pos     (in_pos),
    .in_neg     (in_neg),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_act    (out_act),
    .out_sum    (out_sum),
    .out_chunks (out_chunks),
    .out_sat    (out_sat),
    .out_forced (out_forced)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] p,
                      input logic [3:0] n,
                      input logic l);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_pos   = p;
    in_neg   = n;
    in_last  = l;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_res(input string tag,
                           input logic [7:0] sum,
                           input logic [1:0] act,
                           input logic [4:0] chunks,
                           input logic forced,
                           input logic sat);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_sum"}, 32'(out_sum), 32'(sum));
    check({tag, "_act"}, 32'(out_act), 32'(act));
    check({tag, "_chunks"}, 32'(out_chunks), 32'(chunks));
    check({tag, "_forced"}, 32'(out_forced), 32'(forced));
    check({tag, "_sat"}, 32'(out_sat), 32'(sat));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'd0);
    check({tag, "_act"}, 32'(out_act), 32'd0);
    check({tag, "_chunks"}, 32'(out_chunks), 32'd0);
    check({tag, "_forced"}, 32'(out_forced), 32'd0);
    check({tag, "_sat"}, 32'(out_sat), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Single beat neuron: 9-3 = 6
    check("t1_pre_valid", 32'(out_valid), 32'd0);
    send(4'd9, 4'd3, 1'b1);
    check_res("t1", 8'd6, 2'b01, 5'd1, 1'b0, 1'b0);
    handshake("t1");

    // Three beats: -1+0+0, then stall for 5 cycles
    send(4'd4, 4'd5, 1'b0);
    check("t2_mid_valid", 32'(out_valid), 32'd0);
    send(4'd2, 4'd2, 1'b0);
    send(4'd1, 4'd1, 1'b1);
    check_res("t2", 8'hFF, 2'b00, 5'd3, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_hold%0d", i), 32'(out_sum), 32'hFF);
      check($sformatf("t2_hold_rdy%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("t2_hold_vld%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    check_res("t2_held", 8'hFF, 2'b00, 5'd3, 1'b0, 1'b0);
    handshake("t2");

    // Sixteen beats (0,3) without last: forced close at -48
    for (int i = 0; i < 15; i++) begin
      send(4'd0, 4'd3, 1'b0);
    end
    check("t3_beat15_valid", 32'(out_valid), 32'd0);
    send(4'd0, 4'd3, 1'b0);
    check_res("t3", 8'hD0, 2'b11, 5'd16, 1'b1, 1'b0);
    handshake("t3");

    // Sixteen beats (15,0), last on beat 16
    for (int i = 0; i < 15; i++) begin
      send(4'd15, 4'd0, 1'b0);
    end
    send(4'd15, 4'd0, 1'b1);
`ifdef ACC_SAT_EN
    check_res("t4", 8'h7F, 2'b01, 5'd16, 1'b0, 1'b1);
`else
    check_res("t4", 8'hF0, 2'b11, 5'd16, 1'b0, 1'b0);
`endif
    handshake("t4");
    check("t4_sat_cleared", 32'(out_sat), 32'd0);

    // Reset mid-neuron, with a beat offered during reset
    send(4'd1, 4'd0, 1'b0);
    send(4'd1, 4'd0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_pos   = 4'd7;
    in_neg   = 4'd0;
    in_last  = 1'b1;
    step();
    check_zero("t5_rst");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    check("t5_idle_valid", 32'(out_valid), 32'd0);
    send(4'd3, 4'd0, 1'b1);
    check_res("t5", 8'd3, 2'b01, 5'd1, 1'b0, 1'b0);
    handshake("t5");

    // Back-to-back neurons, out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pos    = 4'd5;
    in_neg    = 4'd0;
    in_last   = 1'b1;
    step();
    check("t6_a_valid", 32'(out_valid), 32'd1);
    check("t6_a_ready", 32'(in_ready), 32'd0);
    check("t6_a_sum", 32'(out_sum), 32'd5);
    in_pos = 4'd0;
    in_neg = 4'd4;
    step();
    check("t6_gap_valid", 32'(out_valid), 32'd0);
    check("t6_gap_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t6_b_valid", 32'(out_valid), 32'd1);
    check("t6_b_sum", 32'(out_sum), 32'hFC);
    check("t6_b_act", 32'(out_act), 32'd3);
    check("t6_b_chunks", 32'(out_chunks), 32'd1);
    step();
    check("t6_done_valid", 32'(out_valid), 32'd0);
    check("t6_done_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
